wb_prog_mem_bridge: RTL and testbench

//  Parametrised Wishbone slave between the management SoC and BANKS single-port-write program SRAM

---
 rtl/prog_mem_pkg.sv | 36 +++
 rtl/wb_prog_mem_bridge_if.sv | 25 ++
 rtl/prog_mem_decode.sv | 50 +++++
 rtl/wb_prog_mem_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_wb_prog_mem_bridge.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the Wishbone program-memory bridge.
//   state_t     : bridge FSM states
//   dec_class_t : address decode result
//   CSR word indices, CTRL/STAT bit positions, selector-width helper
package prog_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_WAIT,
        S_CSR,
        S_NACK,
        S_ACK
    } state_t;

    typedef enum logic [1:0] {
        DEC_MEM,
        DEC_CSR,
        DEC_UNMAPPED
    } dec_class_t;

    // CSR word index within the 8-byte CSR window (byte offset 0x0 / 0x4)
    localparam logic CSR_IDX_CTRL = 1'b0;
    localparam logic CSR_IDX_STAT = 1'b1;
    localparam int unsigned CSR_SPAN = 8;

    localparam int unsigned CTRL_HOLD_BIT = 0;
    localparam int unsigned CTRL_BANK_LSB = 8;
    localparam int unsigned STAT_ERR_BIT  = 0;

    // Width of a field selecting one of n items; never zero
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_prog_mem_bridge_if.sv
// Wishbone slave bus bundle for the program-memory bridge.
//   master : drives cyc/stb/we/sel/adr/dat_i, receives dat_o/ack
//   slave  : the bridge side
interface wb_prog_mem_bridge_if #(
    parameter int unsigned DATA_W = 32
);
    logic                wbs_cyc_i;
    logic                wbs_stb_i;
    logic                wbs_we_i;
    logic [DATA_W/8-1:0] wbs_sel_i;
    logic [31:0]         wbs_adr_i;
    logic [DATA_W-1:0]   wbs_dat_i;
    logic [DATA_W-1:0]   wbs_dat_o;
    logic                wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/prog_mem_decode.sv
// Combinational byte-address decoder for the program-memory window.
//   adr      in  byte address
//   cls      out MEM / CSR / UNMAPPED
//   bank     out SRAM bank (0 when BANKS=1)
//   word     out word address inside the bank
//   csr_idx  out CSR word index (0=CTRL, 1=STAT)
module prog_mem_decode
    import prog_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BANKS     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] CSR_OFFS  = 32'h0001_0000
) (
    input  logic [31:0]              adr,
    output dec_class_t               cls,
    output logic [sel_w(BANKS)-1:0]  bank,
    output logic [ADDR_W-1:0]        word,
    output logic                     csr_idx
);

    localparam logic [31:0] MEM_BYTES = 32'(BANKS * (2 ** ADDR_W) * 4);
    localparam logic [31:0] CSR_END   = CSR_OFFS + 32'(CSR_SPAN);

    logic [31:0] off;

    // Wrapping subtraction: addresses below BASE_ADDR land far above the window
    assign off     = adr - BASE_ADDR;
    assign word    = off[ADDR_W+1:2];
    assign csr_idx = off[2];

    generate
        if (BANKS > 1) begin : g_bank
            assign bank = off[ADDR_W+2 +: $clog2(BANKS)];
        end else begin : g_single
            assign bank = '0;
        end
    endgenerate

    // Memory window takes priority over the CSR window
    always_comb begin
        cls = DEC_UNMAPPED;
        if (off < MEM_BYTES) begin
            cls = DEC_MEM;
        end else if (off >= CSR_OFFS && off < CSR_END) begin
            cls = DEC_CSR;
        end
    end

endmodule

// File: rtl/wb_prog_mem_bridge.sv
// Wishbone slave bridging the management SoC to BANKS program SRAM write/read
// ports, plus a CSR block holding core hold, fetch-bank select and a sticky
// protection-fault flag.
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs                  Wishbone slave bundle
//   mem_csb/web/wmask/addr/din   SRAM port 0 controls (registered)
//   mem_dout             per-bank read data, bank b at [b*DATA_W +: DATA_W]
//   core_hold            1 holds the CPU in reset
//   fetch_bank           bank the CPU fetches from
// mem_dout is sampled at the end of the READ_LAT-th cycle, counting the
// csb-low cycle as the first.
module wb_prog_mem_bridge
    import prog_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BANKS     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] CSR_OFFS  = 32'h0001_0000,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_prog_mem_bridge_if.slave       wbs,
    output logic [BANKS-1:0]          mem_csb,
    output logic                      mem_web,
    output logic [DATA_W/8-1:0]       mem_wmask,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [BANKS*DATA_W-1:0]   mem_dout,
    output logic                      core_hold,
    output logic [sel_w(BANKS)-1:0]   fetch_bank
);

    localparam int unsigned FB_W  = sel_w(BANKS);
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((READ_LAT >= 2) ? READ_LAT - 2 : 0);

    state_t state_q, state_d;

    logic              req_we_q,   req_we_d;
    logic [FB_W-1:0]   req_bank_q, req_bank_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              err_q,      err_d;
    logic              ack_q,      ack_d;
    logic [DATA_W-1:0] dat_q,      dat_d;

    logic [BANKS-1:0]    csb_d;
    logic                web_d;
    logic [DATA_W/8-1:0] wmask_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   din_d;
    logic                hold_d;
    logic [FB_W-1:0]     fb_d;

    dec_class_t        dec_cls;
    logic [FB_W-1:0]   dec_bank;
    logic [ADDR_W-1:0] dec_word;
    logic              dec_csr_idx;

    logic              req_c;
    logic              prot_c;
    logic [DATA_W-1:0] bank_dout_c;
    logic [DATA_W-1:0] csr_rdata_c;

    prog_mem_decode #(
        .ADDR_W    (ADDR_W),
        .BANKS     (BANKS),
        .BASE_ADDR (BASE_ADDR),
        .CSR_OFFS  (CSR_OFFS)
    ) u_decode (
        .adr     (wbs.wbs_adr_i),
        .cls     (dec_cls),
        .bank    (dec_bank),
        .word    (dec_word),
        .csr_idx (dec_csr_idx)
    );

    assign req_c       = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    // Writing the bank the running core fetches from is refused
    assign prot_c      = wbs.wbs_we_i & ~core_hold & (dec_bank == fetch_bank);
    assign bank_dout_c = mem_dout[32'(req_bank_q) * DATA_W +: DATA_W];

    always_comb begin
        csr_rdata_c = '0;
        if (dec_csr_idx == CSR_IDX_CTRL) begin
            csr_rdata_c[CTRL_HOLD_BIT] = core_hold;
            if (BANKS > 1) begin
                csr_rdata_c[CTRL_BANK_LSB +: FB_W] = fetch_bank;
            end
        end else begin
            csr_rdata_c[STAT_ERR_BIT] = err_q;
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped cyc abandons a memory access without ack
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    unique case (dec_cls)
                        DEC_MEM: state_d = S_MEM;
                        DEC_CSR: state_d = S_CSR;
                        default: state_d = S_NACK;
                    endcase
                end
            end
            S_MEM: begin
                if (!wbs.wbs_cyc_i)                    state_d = S_IDLE;
                else if (req_we_q || READ_LAT == 1)    state_d = S_ACK;
                else                                   state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!wbs.wbs_cyc_i)                    state_d = S_IDLE;
                else if (cnt_q == '0)                  state_d = S_ACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        csb_d      = '1;
        web_d      = 1'b1;
        wmask_d    = mem_wmask;
        addr_d     = mem_addr;
        din_d      = mem_din;
        hold_d     = core_hold;
        fb_d       = fetch_bank;
        err_d      = err_q;
        dat_d      = dat_q;
        req_we_d   = req_we_q;
        req_bank_d = req_bank_q;
        cnt_d      = cnt_q;
        ack_d      = (state_d == S_CSR) || (state_d == S_NACK) || (state_d == S_ACK);

        unique case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    req_we_d   = wbs.wbs_we_i;
                    req_bank_d = dec_bank;
                    unique case (dec_cls)
                        DEC_MEM: begin
                            web_d   = ~wbs.wbs_we_i;
                            wmask_d = wbs.wbs_sel_i;
                            addr_d  = dec_word;
                            din_d   = wbs.wbs_dat_i;
                            cnt_d   = WAIT_INIT;
                            if (prot_c) err_d = 1'b1;
                            else        csb_d[dec_bank] = 1'b0;
                        end
                        DEC_CSR: begin
                            if (!wbs.wbs_we_i) begin
                                dat_d = csr_rdata_c;
                            end else if (wbs.wbs_sel_i != '0) begin
                                if (dec_csr_idx == CSR_IDX_CTRL) begin
                                    hold_d = wbs.wbs_dat_i[CTRL_HOLD_BIT];
                                    if (BANKS > 1) begin
                                        fb_d = wbs.wbs_dat_i[CTRL_BANK_LSB +: FB_W];
                                    end
                                end else if (wbs.wbs_dat_i[STAT_ERR_BIT]) begin
                                    err_d = 1'b0;
                                end
                            end
                        end
                        default: dat_d = '0;
                    endcase
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase

        // Read data is captured on the way into the ack cycle
        if (state_d == S_ACK && !req_we_q && (state_q == S_MEM || state_q == S_WAIT)) begin
            dat_d = bank_dout_c;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mem_csb    <= '1;
            mem_web    <= 1'b1;
            mem_wmask  <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            core_hold  <= 1'b1;
            fetch_bank <= '0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            req_we_q   <= 1'b0;
            req_bank_q <= '0;
            cnt_q      <= '0;
        end else begin
            mem_csb    <= csb_d;
            mem_web    <= web_d;
            mem_wmask  <= wmask_d;
            mem_addr   <= addr_d;
            mem_din    <= din_d;
            core_hold  <= hold_d;
            fetch_bank <= fb_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            req_we_q   <= req_we_d;
            req_bank_q <= req_bank_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_prog_mem_bridge.sv
// Scoreboard bench for wb_prog_mem_bridge (BANKS=2, ADDR_W=9, READ_LAT=2).
module tb_wb_prog_mem_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_prog_mem_bridge_if #(.DATA_W(32)) wbs();

    logic [1:0]  mem_csb;
    logic        mem_web;
    logic [3:0]  mem_wmask;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic [63:0] mem_dout;
    logic        core_hold;
    logic [0:0]  fetch_bank;

    wb_prog_mem_bridge #(
        .ADDR_W    (9),
        .DATA_W    (32),
        .BANKS     (2),
        .BASE_ADDR (32'h3000_0000),
        .CSR_OFFS  (32'h0001_0000),
        .READ_LAT  (2)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs        (wbs),
        .mem_csb    (mem_csb),
        .mem_web    (mem_web),
        .mem_wmask  (mem_wmask),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .core_hold  (core_hold),
        .fetch_bank (fetch_bank)
    );

    // Two 1-cycle SRAM banks: dout registered the edge after a csb-low read
    logic [31:0] mem_m [2][512];
    logic [31:0] dout_m [2];
    assign mem_dout = {dout_m[1], dout_m[0]};

    initial begin
        for (int b = 0; b < 2; b++) begin
            dout_m[b] = '0;
            for (int i = 0; i < 512; i++) mem_m[b][i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!mem_csb[b]) begin
                if (!mem_web) begin
                    for (int l = 0; l < 4; l++)
                        if (mem_wmask[l]) mem_m[b][mem_addr][l*8 +: 8] = mem_din[l*8 +: 8];
                end else begin
                    dout_m[b] <= mem_m[b][mem_addr];
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int acks_seen = 0;
    int low_cnt [2] = '{0, 0};
    logic [8:0]  last_addr;
    logic [3:0]  last_wmask;
    logic        last_web;
    logic [31:0] last_din;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        chk_dat;
        logic [31:0] dat;
        int          ack_cyc;
    } exp_t;

    exp_t sb[$];

    // Monitor: every ack pops one expectation
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!mem_csb[b]) begin
                low_cnt[b]++;
                last_addr  = mem_addr;
                last_wmask = mem_wmask;
                last_web   = mem_web;
                last_din   = mem_din;
            end
        end
        if (wbs.wbs_ack_o) begin
            exp_t e;
            acks_seen++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_ack_cycle"}, 32'(cyc_n), 32'(e.ack_cyc));
                if (e.chk_dat) check({e.name, "_dat"}, wbs.wbs_dat_o, e.dat);
            end
        end
    end

    task automatic idle_bus();
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = '0;
        wbs.wbs_adr_i = '0;
        wbs.wbs_dat_i = '0;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_sel_i = sel;
        wbs.wbs_adr_i = adr;
        wbs.wbs_dat_i = wdat;
    endtask

    // One Wishbone transfer; lat = ack cycle relative to request cycle T
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdat, input logic chk_dat, input logic [31:0] exp_dat,
                        input int lat, input string name);
        exp_t e;
        int waited;
        @(posedge clk); #1;
        drive(we, adr, sel, wdat);
        e.name = name; e.chk_dat = chk_dat; e.dat = exp_dat; e.ack_cyc = cyc_n + lat;
        sb.push_back(e);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wbs.wbs_ack_o && waited < 12);
        if (!wbs.wbs_ack_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no ack after %0d cycles, expected at +%0d", name, waited, lat);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
        @(posedge clk); #1;
        idle_bus();
    endtask

    localparam logic [31:0] A_CTRL = 32'h3001_0000;
    localparam logic [31:0] A_STAT = 32'h3001_0004;

    initial begin
        int c0, c1, a0;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_csb",   32'(mem_csb), 32'h3);
        check("rst_web",   32'(mem_web), 32'h1);
        check("rst_ack",   32'(wbs.wbs_ack_o), 32'h0);
        check("rst_dat",   wbs.wbs_dat_o, 32'h0);
        check("rst_hold",  32'(core_hold), 32'h1);
        check("rst_fbank", 32'(fetch_bank), 32'h0);

        xfer(1'b0, A_CTRL, 4'hF, 32'h0, 1'b1, 32'h0000_0001, 1, "rd_ctrl_rst");

        // Bank 1, word 1, lower two byte lanes
        c0 = low_cnt[0]; c1 = low_cnt[1];
        xfer(1'b1, 32'h3000_0804, 4'b0011, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, "wr_b1w1");
        check("wr_b1w1_csb1_cycles", 32'(low_cnt[1] - c1), 32'd1);
        check("wr_b1w1_csb0_cycles", 32'(low_cnt[0] - c0), 32'd0);
        check("wr_b1w1_addr",  32'(last_addr), 32'd1);
        check("wr_b1w1_wmask", 32'(last_wmask), 32'b0011);
        check("wr_b1w1_web",   32'(last_web), 32'd0);
        check("wr_b1w1_din",   last_din, 32'hDEAD_BEEF);

        xfer(1'b0, 32'h3000_0804, 4'hF, 32'h0, 1'b1, 32'h0000_BEEF, 3, "rd_b1w1");

        // Release core, fetch bank 0; bank-0 writes are now protected
        xfer(1'b1, A_CTRL, 4'hF, 32'h0, 1'b0, 32'h0, 1, "wr_ctrl_run");
        check("run_hold", 32'(core_hold), 32'h0);
        c0 = low_cnt[0]; c1 = low_cnt[1];
        xfer(1'b1, 32'h3000_0000, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 2, "wr_prot");
        check("wr_prot_csb0_cycles", 32'(low_cnt[0] - c0), 32'd0);
        check("wr_prot_csb1_cycles", 32'(low_cnt[1] - c1), 32'd0);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, 1'b1, 32'h1, 1, "rd_stat_err");
        xfer(1'b1, A_STAT, 4'hF, 32'h1, 1'b0, 32'h0, 1, "w1c_stat");
        xfer(1'b0, A_STAT, 4'hF, 32'h0, 1'b1, 32'h0, 1, "rd_stat_clr");
        xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0, 1'b1, 32'h0, 3, "rd_b0w0_unwritten");

        // Double buffering: other bank writable while running
        c1 = low_cnt[1];
        xfer(1'b1, 32'h3000_0808, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, 2, "wr_b1w2_run");
        check("wr_b1w2_csb1_cycles", 32'(low_cnt[1] - c1), 32'd1);
        xfer(1'b0, 32'h3000_0808, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, 3, "rd_b1w2");
        xfer(1'b1, A_CTRL, 4'hF, 32'h0000_0100, 1'b0, 32'h0, 1, "wr_ctrl_flip");
        check("flip_fbank", 32'(fetch_bank), 32'h1);
        xfer(1'b0, A_CTRL, 4'hF, 32'h0, 1'b1, 32'h0000_0100, 1, "rd_ctrl_flip");

        xfer(1'b0, 32'h3002_0000, 4'hF, 32'h0, 1'b1, 32'h0, 1, "rd_unmapped");

        // Drop cyc while waiting on read data: no ack, back to IDLE
        a0 = acks_seen;
        @(posedge clk); #1;
        drive(1'b0, 32'h3000_0804, 4'hF, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_bus();
        repeat (5) @(negedge clk);
        check("drop_no_ack", 32'(acks_seen - a0), 32'd0);
        xfer(1'b0, A_CTRL, 4'hF, 32'h0, 1'b1, 32'h0000_0100, 1, "rd_ctrl_after_drop");

        // Reset in WAIT: ack never rises, CSRs back to reset values
        a0 = acks_seen;
        @(posedge clk); #1;
        drive(1'b0, 32'h3000_0804, 4'hF, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bus();
        repeat (4) @(negedge clk);
        check("rst_wait_no_ack", 32'(acks_seen - a0), 32'd0);
        check("rst_wait_csb",    32'(mem_csb), 32'h3);
        check("rst_wait_hold",   32'(core_hold), 32'h1);
        xfer(1'b0, A_CTRL, 4'hF, 32'h0, 1'b1, 32'h0000_0001, 1, "rd_ctrl_after_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
